// File: rtl/nested_select_engine.sv
// Leaf evaluation unit: computes BASE + (x==0 ? C1A : C1B) + (y==C2_CMP ? C2A : C2B)
// over a valid/ready handshake, with optional accumulation and a completion counter.
module nested_select_engine #(
    parameter int          WIDTH  = 32,
    parameter int          CNT_W  = 8,
    parameter int unsigned BASE   = 32'd1,
    parameter int unsigned C1A    = 32'd1,
    parameter int unsigned C1B    = 32'd2,
    parameter int unsigned C2_CMP = 32'd100,
    parameter int unsigned C2A    = 32'd50,
    parameter int unsigned C2B    = 32'd5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out1,
    output logic [CNT_W-1:0] eval_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        ST_INITIAL = 3'd0,
        ST_IDLE    = 3'd1,
        ST_OUTER   = 3'd2,
        ST_INNER   = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    // Constants are truncated to the datapath width so the compare is a true WIDTH-bit equality.
    localparam logic [WIDTH-1:0] BASE_T   = WIDTH'(BASE);
    localparam logic [WIDTH-1:0] C1A_T    = WIDTH'(C1A);
    localparam logic [WIDTH-1:0] C1B_T    = WIDTH'(C1B);
    localparam logic [WIDTH-1:0] C2_CMP_T = WIDTH'(C2_CMP);
    localparam logic [WIDTH-1:0] C2A_T    = WIDTH'(C2A);
    localparam logic [WIDTH-1:0] C2B_T    = WIDTH'(C2B);

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic             mode_r;
    logic [WIDTH-1:0] term1_r;
    logic [WIDTH-1:0] term2_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] out1_r;
    logic [CNT_W-1:0] eval_count_r;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_INITIAL;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; unused encodings recover through INITIAL.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_INITIAL: state_next_s = ST_IDLE;
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_OUTER;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_OUTER: state_next_s = ST_INNER;
            ST_INNER: state_next_s = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_INITIAL;
        endcase
    end

    // Inner term and truncated sum, only consumed while in INNER.
    always_comb begin
        term2_s = (y_r == C2_CMP_T) ? C2A_T : C2B_T;
        sum_s   = BASE_T + term1_r + term2_s;
    end

    // Operand capture, term pipeline, result and completion counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_r          <= '0;
            y_r          <= '0;
            mode_r       <= 1'b0;
            term1_r      <= '0;
            out1_r       <= '0;
            eval_count_r <= '0;
        end else begin
            case (state_r)
                ST_INITIAL: out1_r <= '0;
                ST_IDLE: begin
                    if (in_valid) begin
                        x_r    <= in_x;
                        y_r    <= in_y;
                        mode_r <= in_mode;
                    end
                end
                ST_OUTER: term1_r <= (x_r == '0) ? C1A_T : C1B_T;
                ST_INNER: out1_r <= mode_r ? (out1_r + sum_s) : sum_s;
                ST_HOLD: begin
                    if (out_ready) begin
                        eval_count_r <= eval_count_r + CNT_W'(1);
                    end
                end
                default: out1_r <= out1_r;
            endcase
        end
    end

    assign in_ready   = (state_r == ST_IDLE);
    assign out_valid  = (state_r == ST_HOLD);
    assign busy       = (state_r != ST_IDLE);
    assign out1       = out1_r;
    assign eval_count = eval_count_r;

endmodule

// File: tb/tb_nested_select_engine.sv
// Bench for nested_select_engine: a 32-bit instance and an 8-bit/2-bit-counter instance share stimulus.
module tb_nested_select_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_mode;
    logic        out_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;

    logic        a_in_ready, a_out_valid, a_busy;
    logic [31:0] a_out1;
    logic [7:0]  a_eval_count;
    logic        b_in_ready, b_out_valid, b_busy;
    logic [7:0]  b_out1;
    logic [1:0]  b_eval_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt      = 0;
    logic [31:0] acc_a;
    logic [7:0]  acc_b;

    always #5 clk = ~clk;

    nested_select_engine dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_x(in_x), .in_y(in_y), .in_mode(in_mode), .out_valid(a_out_valid),
        .out_ready(out_ready), .out1(a_out1), .eval_count(a_eval_count), .busy(a_busy)
    );

    nested_select_engine #(.WIDTH(8), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_x(in_x[7:0]), .in_y(in_y[7:0]), .in_mode(in_mode), .out_valid(b_out_valid),
        .out_ready(out_ready), .out1(b_out1), .eval_count(b_eval_count), .busy(b_busy)
    );

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        mode;
        int          hold;
        logic [31:0] exp_a;
        logic [7:0]  exp_b;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: the nested conditional sum evaluated at a given datapath width.
    function automatic logic [31:0] ref_sum(input logic [31:0] x, input logic [31:0] y, input int w);
        logic [31:0] m;
        logic [31:0] s;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        s = 32'd1 + (((x & m) == 32'd0) ? 32'd1 : 32'd2) + (((y & m) == 32'd100) ? 32'd50 : 32'd5);
        return s & m;
    endfunction

    task automatic run_req(input logic [31:0] x, input logic [31:0] y, input logic m, input int hold,
                           input logic [31:0] exp_a, input logic [7:0] exp_b);
        int n;
        n = 0;
        while (!(a_in_ready && b_in_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(a_in_ready & b_in_ready), 32'd1);
        in_valid = 1'b1; in_x = x; in_y = y; in_mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0; in_x = $urandom; in_y = $urandom; in_mode = 1'($urandom);
        @(negedge clk);
        chk("lat_outer_valid", 32'(a_out_valid | b_out_valid), 32'd0);
        chk("lat_outer_busy", 32'(a_busy & b_busy), 32'd1);
        @(negedge clk);
        chk("lat_inner_valid", 32'(a_out_valid | b_out_valid), 32'd0);
        @(negedge clk);
        chk("a_out_valid", 32'(a_out_valid), 32'd1);
        chk("b_out_valid", 32'(b_out_valid), 32'd1);
        chk("a_out1", a_out1, exp_a);
        chk("b_out1", 32'(b_out1), 32'(exp_b));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 32'(a_out_valid & b_out_valid), 32'd1);
            chk("hold_a_out1", a_out1, exp_a);
            chk("hold_b_out1", 32'(b_out1), 32'(exp_b));
            chk("hold_in_ready", 32'(a_in_ready | b_in_ready), 32'd0);
            chk("hold_a_cnt", 32'(a_eval_count), 32'(cnt & 255));
        end
        out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        cnt++;
        @(negedge clk);
        chk("consume_to_idle", 32'(a_in_ready & b_in_ready), 32'd1);
        chk("consume_valid_low", 32'(a_out_valid | b_out_valid), 32'd0);
        chk("a_eval_count", 32'(a_eval_count), 32'(cnt & 255));
        chk("b_eval_count", 32'(b_eval_count), 32'(cnt & 3));
    endtask

    initial begin
        logic [31:0] rx, ry, sa, sb, ea;
        logic [7:0]  eb;
        logic        rm;

        vecs[0]  = '{32'd5, 32'd7,   1'b0, 1,  32'd8,   8'd8};
        vecs[1]  = '{32'd0, 32'd100, 1'b0, 10, 32'd52,  8'd52};
        vecs[2]  = '{32'd0, 32'd3,   1'b0, 0,  32'd7,   8'd7};
        vecs[3]  = '{32'd9, 32'd100, 1'b0, 2,  32'd53,  8'd53};
        vecs[4]  = '{32'd1, 32'd1,   1'b0, 0,  32'd8,   8'd8};
        vecs[5]  = '{32'd1, 32'd1,   1'b1, 0,  32'd16,  8'd16};
        vecs[6]  = '{32'd1, 32'd1,   1'b1, 1,  32'd24,  8'd24};
        vecs[7]  = '{32'd1, 32'd1,   1'b1, 0,  32'd32,  8'd32};
        vecs[8]  = '{32'd9, 32'd100, 1'b0, 0,  32'd53,  8'd53};
        vecs[9]  = '{32'd9, 32'd100, 1'b1, 0,  32'd106, 8'd106};
        vecs[10] = '{32'd9, 32'd100, 1'b1, 0,  32'd159, 8'd159};
        vecs[11] = '{32'd9, 32'd100, 1'b1, 0,  32'd212, 8'd212};
        vecs[12] = '{32'd0, 32'd3,   1'b1, 0,  32'd219, 8'd219};
        vecs[13] = '{32'd0, 32'd3,   1'b1, 0,  32'd226, 8'd226};
        vecs[14] = '{32'd5, 32'd7,   1'b1, 0,  32'd234, 8'd234};
        vecs[15] = '{32'd5, 32'd7,   1'b1, 0,  32'd242, 8'd242};
        vecs[16] = '{32'd5, 32'd7,   1'b1, 0,  32'd250, 8'd250};
        vecs[17] = '{32'd5, 32'd7,   1'b1, 1,  32'd258, 8'd2};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mode = 1'b0;
        in_x = 32'd0; in_y = 32'd0;
        @(negedge clk);
        chk("rst_a_out1", a_out1, 32'd0);
        chk("rst_b_out1", 32'(b_out1), 32'd0);
        chk("rst_eval_count", 32'(a_eval_count) | 32'(b_eval_count), 32'd0);
        chk("rst_out_valid", 32'(a_out_valid | b_out_valid), 32'd0);
        chk("rst_in_ready", 32'(a_in_ready | b_in_ready), 32'd0);
        chk("rst_busy", 32'(a_busy & b_busy), 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("initial_busy", 32'(a_busy & b_busy), 32'd1);
        chk("initial_in_ready", 32'(a_in_ready), 32'd0);

        for (int i = 0; i < 18; i++) begin
            run_req(vecs[i].x, vecs[i].y, vecs[i].mode, vecs[i].hold, vecs[i].exp_a, vecs[i].exp_b);
            if (i == 4) begin
                chk("b_cnt_wrap_5", 32'(b_eval_count), 32'd1);
                chk("a_cnt_5", 32'(a_eval_count), 32'd5);
            end
        end

        // Abort an evaluation by asserting reset while it sits in INNER.
        in_valid = 1'b1; in_x = 32'd0; in_y = 32'd100; in_mode = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_a_out1", a_out1, 32'd0);
        chk("abort_b_out1", 32'(b_out1), 32'd0);
        chk("abort_out_valid", 32'(a_out_valid | b_out_valid), 32'd0);
        chk("abort_eval_count", 32'(a_eval_count) | 32'(b_eval_count), 32'd0);
        chk("abort_busy", 32'(a_busy & b_busy), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(a_in_ready & b_in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_valid", 32'(a_out_valid | b_out_valid), 32'd0);
            chk("abort_out1_kept", a_out1, 32'd0);
        end
        cnt = 0; acc_a = 32'd0; acc_b = 8'd0;

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: rx = 32'd0;
                1: rx = 32'd256;
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0: ry = 32'd100;
                1: ry = 32'd356;
                default: ry = $urandom;
            endcase
            rm = 1'($urandom);
            sa = ref_sum(rx, ry, 32);
            sb = ref_sum(rx, ry, 8);
            ea = rm ? (acc_a + sa) : sa;
            eb = rm ? (acc_b + sb[7:0]) : sb[7:0];
            run_req(rx, ry, rm, $urandom_range(0, 3), ea, eb);
            acc_a = ea;
            acc_b = eb;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
